// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state, width defaults and slice index type for the serial adder
package alu_pkg;
   localparam int DEF_WIDTH = 64;
   localparam int DEF_SLICE = 16;
   localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef logic [$clog2(DEF_NSLICE)-1:0] slice_idx_t;
endpackage

// File: rtl/add64_serial_fa16.sv
// FullAdder16: 16-bit ripple-carry slice adder
module FullAdder16 (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] S,
   output logic        Cout
);
   logic [16:0] c;
   assign c[0] = Cin;
   assign Cout = c[16];
   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign S[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end
endmodule

// File: rtl/add64_serial.sv
// add64_serial: 64-bit add/sub built from one 16-bit slice adder reused over four cycles
module add64_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);
   localparam int NS = WIDTH / SLICE;
   state_t           state;
   slice_idx_t       idx;
   logic             carry;
   logic [WIDTH-1:0] a_r, b_r, sum_nx;
   logic [SLICE-1:0] s_s;
   logic             s_c;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   FullAdder16 u_fa (
      .A    (a_r[idx*SLICE +: SLICE]),
      .B    (b_r[idx*SLICE +: SLICE]),
      .Cin  (carry),
      .S    (s_s),
      .Cout (s_c)
   );
   // full result as it will look after this edge, so flags see the final slice
   always_comb begin
      sum_nx = sum;
      sum_nx[idx*SLICE +: SLICE] = s_s;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r   <= a;
               b_r   <= b ^ {WIDTH{sub}};
               carry <= sub;
               idx   <= '0;
               state <= RUN;
            end
            RUN: begin
               sum   <= sum_nx;
               carry <= s_c;
               idx   <= idx + 1'b1;
               if (idx == slice_idx_t'(NS - 1)) begin
                  state    <= DONE;
                  cout     <= s_c;
                  overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nx[WIDTH-1] != a_r[WIDTH-1]);
                  zero     <= ~|sum_nx;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add64_serial.sv
// tb_add64_serial: directed table, random ops against an arithmetic model, handshake and reset cases
module tb_add64_serial;
   logic        clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 0;
   logic [63:0] a = '0, b = '0;
   logic        in_ready, out_valid, cout, overflow, zero;
   logic [63:0] sum;
   int          tests = 0, fails = 0;

   add64_serial dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a, b;
      logic        sub;
      logic [63:0] s;
      logic        c, ov, z;
   } vec_t;
   vec_t vt[6];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // plain two's-complement arithmetic: {sum, cout, overflow, zero}
   function automatic logic [66:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
      logic [63:0]        r;
      logic               c;
      logic signed [64:0] w;
      if (s) begin
         r = x - y;
         c = (x >= y);
         w = $signed({x[63], x}) - $signed({y[63], y});
      end else begin
         {c, r} = {1'b0, x} + {1'b0, y};
         w = $signed({x[63], x}) + $signed({y[63], y});
      end
      return {r, c, w[64] != w[63], r == 64'd0};
   endfunction

   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                         output logic [63:0] rs, output logic rc, output logic rov,
                         output logic rz, output int lat);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      a = ta; b = tb; sub = ts; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0; a = $urandom; b = {$urandom, $urandom}; sub = $urandom;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      rs = sum; rc = cout; rov = overflow; rz = zero;
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1; out_ready = 0;
   endtask

   logic [63:0] rs, held;
   logic        rc, rov, rz;
   logic [66:0] m;
   int          lat;

   initial begin
      vt[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
      vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
      vt[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
      vt[4] = '{64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
      vt[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};

      #12;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset sum", sum, 0);
      chk("reset flags", {cout, overflow, zero}, 0);
      @(negedge clk); rst_n = 1;

      for (int i = 0; i < 6; i++) begin
         run_op(vt[i].a, vt[i].b, vt[i].sub, rs, rc, rov, rz, lat);
         chk($sformatf("vec%0d latency", i), lat, 4);
         chk($sformatf("vec%0d sum", i), rs, vt[i].s);
         chk($sformatf("vec%0d cout", i), rc, vt[i].c);
         chk($sformatf("vec%0d overflow", i), rov, vt[i].ov);
         chk($sformatf("vec%0d zero", i), rz, vt[i].z);
      end
      chk("idle after handshake", in_ready, 1);

      for (int i = 0; i < 40; i++) begin
         logic [63:0] x, y;
         logic        s;
         x = {$urandom, $urandom};
         y = (i % 5 == 0) ? x : {$urandom, $urandom};
         s = $urandom;
         if (i % 7 == 0) y[63] = ~x[63] ^ s;
         m = model(x, y, s);
         run_op(x, y, s, rs, rc, rov, rz, lat);
         chk($sformatf("rand%0d result", i), {rs, rc, rov, rz}, m);
      end

      // back-pressure: DONE holds, in_ready low, extra in_valid ignored
      @(negedge clk);
      a = 64'h1234; b = 64'h1111; sub = 0; in_valid = 1;
      @(posedge clk); #1;
      a = 64'hDEAD_BEEF; b = 64'h1; sub = 1;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("bp latency", lat, 4);
      held = sum;
      chk("bp sum", held, 64'h2345);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d", i), {out_valid, in_ready, sum}, {1'b1, 1'b0, held});
      end
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bp released idle", {out_valid, in_ready}, 2'b01);
      @(posedge clk); #1;
      in_valid = 0;
      chk("bp next accepted", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("bp next latency", lat, 4);
      chk("bp next sum", sum, 64'hDEAD_BEEE);
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1; out_ready = 0;

      // reset with idx == 2
      @(negedge clk);
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; sub = 0; in_valid = 1;
      @(posedge clk); #1; in_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 0;
      #1;
      chk("midrun reset outputs", {out_valid, sum, cout, overflow, zero}, '0);
      chk("midrun reset in_ready", in_ready, 1);
      @(negedge clk);
      chk("midrun reset held", {in_ready, out_valid}, 2'b10);
      rst_n = 1;
      run_op(64'd3, 64'd4, 1'b0, rs, rc, rov, rz, lat);
      chk("post reset latency", lat, 4);
      chk("post reset sum", rs, 64'd7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
